// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus/opcode widths and the opcode map used by the
// instruction decoder and the control FSM.
package cpu_pkg;

  localparam int unsigned CPU_DATA_W = 8;
  localparam int unsigned CPU_OP_W   = 4;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_STA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_XOR = 4'h4,
    OP_INC = 4'h5,
    OP_CLR = 4'h6,
    OP_JMP = 4'h7,
    OP_JPZ = 4'h8,
    OP_JPN = 4'h9,
    OP_HLT = 4'hF
  } opcode_e;

  // Opcodes A..E are unassigned.
  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/ir_flag_reg.sv
// Z/N condition flag register, loaded from the accumulator value.
module ir_flag_reg
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] acc_in,
  output logic              z_flag,
  output logic              n_flag
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      z_flag <= 1'b1;
      n_flag <= 1'b0;
    end else if (load) begin
      z_flag <= (acc_in == '0);
      n_flag <= acc_in[DATA_W-1];
    end
  end

endmodule

// File: rtl/ir_decoder.sv
// Instruction register and one-hot opcode decoder with Z/N flags.
// Optional macro IR_DECODER_ILLEGAL_TRAP_EN: illegal opcodes halt the CPU.
module ir_decoder
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_DATA_W,
  parameter int unsigned OP_W   = CPU_OP_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        bus_in,
  input  logic                     ir_load,
  input  logic [DATA_W-1:0]        acc_in,
  input  logic                     flag_load,
  output logic                     LDA,
  output logic                     STA,
  output logic                     ADD,
  output logic                     SUB,
  output logic                     XOR,
  output logic                     INC,
  output logic                     CLR,
  output logic                     JMP,
  output logic                     JPZ,
  output logic                     JPN,
  output logic                     HLT,
  output logic [DATA_W-OP_W-1:0]   addr_out,
  output logic                     z_flag,
  output logic                     n_flag,
  output logic                     halted,
  output logic                     illegal
);

  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic              accept;
  logic              load_halts;
  opcode_e           ir_op;
  opcode_e           bus_op;

  assign ir_op  = opcode_e'(ir[DATA_W-1 -: OP_W]);
  assign bus_op = opcode_e'(bus_in[DATA_W-1 -: OP_W]);
  assign accept = ir_load && !halted;

`ifdef IR_DECODER_ILLEGAL_TRAP_EN
  assign load_halts = (bus_op == OP_HLT) || is_illegal(bus_op);
`else
  assign load_halts = (bus_op == OP_HLT);
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      ir       <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else if (accept) begin
      ir       <= bus_in;
      ir_valid <= 1'b1;
      if (load_halts)
        halted <= 1'b1;
    end
  end

`ifdef IR_DECODER_ILLEGAL_TRAP_EN
  always_ff @(posedge clock) begin
    if (!reset)
      illegal <= 1'b0;
    else if (accept && is_illegal(bus_op))
      illegal <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

  ir_flag_reg #(
    .DATA_W (DATA_W)
  ) u_flags (
    .clock  (clock),
    .reset  (reset),
    .load   (flag_load),
    .acc_in (acc_in),
    .z_flag (z_flag),
    .n_flag (n_flag)
  );

  assign addr_out = ir[DATA_W-OP_W-1:0];

  always_comb begin
    LDA = 1'b0;
    STA = 1'b0;
    ADD = 1'b0;
    SUB = 1'b0;
    XOR = 1'b0;
    INC = 1'b0;
    CLR = 1'b0;
    JMP = 1'b0;
    JPZ = 1'b0;
    JPN = 1'b0;
    HLT = 1'b0;
    if (ir_valid) begin
      // A trapped illegal opcode leaves halted set without an F in IR.
      if (halted) begin
        HLT = 1'b1;
      end else begin
        case (ir_op)
          OP_LDA:  LDA = 1'b1;
          OP_STA:  STA = 1'b1;
          OP_ADD:  ADD = 1'b1;
          OP_SUB:  SUB = 1'b1;
          OP_XOR:  XOR = 1'b1;
          OP_INC:  INC = 1'b1;
          OP_CLR:  CLR = 1'b1;
          OP_JMP:  JMP = 1'b1;
          OP_JPZ:  JPZ = z_flag;
          OP_JPN:  JPN = n_flag;
          OP_HLT:  HLT = 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_decoder.sv
// Self-checking bench for ir_decoder: behavioural model plus directed vectors.
module tb_ir_decoder;

`ifdef IR_DECODER_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] bus_in = '0;
  logic       ir_load = 1'b0;
  logic [7:0] acc_in = '0;
  logic       flag_load = 1'b0;
  logic LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT;
  logic [3:0] addr_out;
  logic       z_flag, n_flag, halted, illegal;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clock = ~clock;

  ir_decoder #(.DATA_W(8), .OP_W(4)) dut (
    .clock(clock), .reset(reset), .bus_in(bus_in), .ir_load(ir_load),
    .acc_in(acc_in), .flag_load(flag_load),
    .LDA(LDA), .STA(STA), .ADD(ADD), .SUB(SUB), .XOR(XOR), .INC(INC),
    .CLR(CLR), .JMP(JMP), .JPZ(JPZ), .JPN(JPN), .HLT(HLT),
    .addr_out(addr_out), .z_flag(z_flag), .n_flag(n_flag),
    .halted(halted), .illegal(illegal)
  );

  // Bit index equals opcode for 0..9; bit 10 is HLT.
  logic [10:0] dut_lines;
  assign dut_lines = {HLT, JPN, JPZ, JMP, CLR, INC, XOR, SUB, ADD, STA, LDA};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the architectural state.
  logic [7:0] m_ir;
  bit m_valid, m_z, m_n, m_halt, m_ill, m_ready;
  initial m_ready = 1'b0;

  always @(posedge clock) begin
    int unsigned op;
    if (!reset) begin
      m_ir = 8'h00; m_valid = 0; m_z = 1; m_n = 0; m_halt = 0; m_ill = 0;
      m_ready = 1;
    end else begin
      if (flag_load) begin
        m_z = (acc_in == 8'h00);
        m_n = acc_in[7];
      end
      if (ir_load && !m_halt) begin
        m_ir = bus_in;
        m_valid = 1;
        op = int'(bus_in) / 16;
        if (op == 15) m_halt = 1;
        if (op >= 10 && op <= 14 && TRAP) begin
          m_ill = 1;
          m_halt = 1;
        end
      end
    end
  end

  function automatic logic [10:0] exp_lines();
    int unsigned op;
    op = int'(m_ir) / 16;
    if (!m_valid) return '0;
    if (m_halt) return 11'h400;
    if (op <= 7) return 11'(1 << op);
    if (op == 8) return m_z ? 11'h100 : 11'h000;
    if (op == 9) return m_n ? 11'h200 : 11'h000;
    if (op == 15) return 11'h400;
    return '0;
  endfunction

  always @(negedge clock) begin
    if (m_ready) begin
      check("lines",   32'(dut_lines), 32'(exp_lines()));
      check("addr",    32'(addr_out),  32'(m_ir % 16));
      check("z_flag",  32'(z_flag),    32'(m_z));
      check("n_flag",  32'(n_flag),    32'(m_n));
      check("halted",  32'(halted),    32'(m_halt));
      check("illegal", 32'(illegal),   32'(m_ill));
      check("onehot",  32'($countones(dut_lines) <= 1), 32'd1);
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic load(input logic [7:0] b);
    ir_load = 1'b1;
    bus_in  = b;
    step();
    ir_load = 1'b0;
  endtask

  task automatic flags(input logic [7:0] a);
    flag_load = 1'b1;
    acc_in    = a;
    step();
    flag_load = 1'b0;
  endtask

  logic [7:0] table_b [6] = '{8'h0C, 8'h17, 8'h33, 8'h4F, 8'h61, 8'h7E};

  initial begin
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    step(); step(); step();
    check("rst_lines",   32'(dut_lines), 32'h0);
    check("rst_z",       32'(z_flag),    32'h1);
    check("rst_n",       32'(n_flag),    32'h0);
    check("rst_halted",  32'(halted),    32'h0);
    check("rst_illegal", 32'(illegal),   32'h0);

    load(8'h2A);
    check("add_lines", 32'(dut_lines), 32'h004);
    check("add_addr",  32'(addr_out),  32'hA);
    step(); step();
    check("add_held",  32'(dut_lines), 32'h004);

    flags(8'h00);
    load(8'h85);
    check("jpz_taken", 32'(dut_lines), 32'h100);
    flags(8'h80);
    load(8'h85);
    check("jpz_not",   32'(dut_lines), 32'h000);
    check("jpz_n",     32'(n_flag),    32'h1);
    load(8'h93);
    check("jpn_taken", 32'(dut_lines), 32'h200);

    for (int i = 0; i < 6; i++) begin
      load(table_b[i]);
      check("table_lines", 32'(dut_lines), 32'(1 << (table_b[i] / 16)));
      check("table_addr",  32'(addr_out),  32'(table_b[i] % 16));
    end

    load(8'hF0);
    check("hlt_lines",  32'(dut_lines), 32'h400);
    check("hlt_halted", 32'(halted),    32'h1);
    load(8'h12);
    check("hlt_frozen", 32'(dut_lines), 32'h400);
    check("hlt_addr",   32'(addr_out),  32'h0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("hlt_cleared", 32'(halted),    32'h0);
    check("hlt_rst_ln",  32'(dut_lines), 32'h0);

    flags(8'h01);
    ir_load = 1'b1; bus_in = 8'h81;
    flag_load = 1'b1; acc_in = 8'h00;
    step();
    ir_load = 1'b0; flag_load = 1'b0;
    check("same_cycle_jpz", 32'(dut_lines), 32'h100);

    load(8'hB7);
`ifdef IR_DECODER_ILLEGAL_TRAP_EN
    check("ill_flag",   32'(illegal),   32'h1);
    check("ill_halted", 32'(halted),    32'h1);
    check("ill_lines",  32'(dut_lines), 32'h400);
    load(8'h50);
    check("ill_frozen", 32'(dut_lines), 32'h400);
    check("ill_addr",   32'(addr_out),  32'h7);
`else
    check("ill_flag",   32'(illegal),   32'h0);
    check("ill_halted", 32'(halted),    32'h0);
    check("ill_lines",  32'(dut_lines), 32'h000);
    load(8'h50);
    check("inc_lines",  32'(dut_lines), 32'h020);
    check("inc_addr",   32'(addr_out),  32'h0);
`endif

    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("final_illegal", 32'(illegal), 32'h0);
    check("final_halted",  32'(halted),  32'h0);

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
